// File: rtl/bp_fe_replay_queue.sv
// bp_fe_replay_queue: rollback queue between the fetch-address source and the I$.
// Entries stay resident after being read until committed; a roll rewinds the
// read pointer to the oldest uncommitted entry so missed fetches are replayed.
// Up to commit_width_p entries can be retired per cycle.
//
// Optional feature: define BP_FE_REPLAY_QUEUE_STATS_EN to add the saturating
// roll_cnt_o / replay_cnt_o statistics counters. Without it the ports and the
// counter logic are absent; the core queue behaves identically in both builds.
//
// Handshake: enqueue happens when v_i & ready_o; dequeue (read) happens when
// yumi_i is high, and yumi_i may only be raised while v_o is high. ready_o and
// v_o are functions of registered state only, never of same-cycle inputs.
module bp_fe_replay_queue #(
  parameter int width_p        = 64,
  parameter int els_p          = 8,
  parameter int commit_width_p = 2,
  localparam int addr_w        = $clog2(els_p),
  localparam int ptr_w         = addr_w + 1,
  localparam int cnt_w         = $clog2(els_p + 1),
  localparam int ccw           = $clog2(commit_width_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clr_v_i,
  input  logic               roll_v_i,
  input  logic [ccw-1:0]     commit_cnt_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i,
  output logic [cnt_w-1:0]   count_o,
  output logic [cnt_w-1:0]   inflight_o
`ifdef BP_FE_REPLAY_QUEUE_STATS_EN
  ,
  output logic [31:0]        roll_cnt_o,
  output logic [31:0]        replay_cnt_o
`endif
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ptr_w-1:0]   wptr_r, rptr_r, cptr_r;
  logic [ptr_w-1:0]   wptr_n, rptr_n, cptr_n;
  logic               enq;
  logic [width_p-1:0] mem [els_p];

  assign count_o    = cnt_w'(wptr_r - cptr_r);
  assign inflight_o = cnt_w'(rptr_r - cptr_r);
  assign ready_o    = (count_o != cnt_w'(els_p));
  assign v_o        = (rptr_r != wptr_r);
  assign data_o     = mem[rptr_r[addr_w-1:0]];

  // A clear drops any same-cycle enqueue, so it is folded into the write enable.
  assign enq = v_i & ready_o & ~clr_v_i;

  // Next-pointer logic: clear > roll > (enqueue, yumi, commit concurrently).
  always_comb begin
    wptr_n = wptr_r;
    rptr_n = rptr_r;
    cptr_n = cptr_r;
    if (clr_v_i) begin
      rptr_n = wptr_r;
      cptr_n = wptr_r;
    end else begin
      wptr_n = wptr_r + ptr_w'(enq);
      cptr_n = cptr_r + ptr_w'(commit_cnt_i);
      // The rewind lands after this cycle's commit; a yumi in a roll cycle is lost.
      if (roll_v_i) rptr_n = cptr_n;
      else          rptr_n = rptr_r + ptr_w'(yumi_i);
    end
  end

  // Pointer registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cptr_r <= '0;
    end else begin
      wptr_r <= wptr_n;
      rptr_r <= rptr_n;
      cptr_r <= cptr_n;
    end
  end

  // Storage write port; contents are not reset, pointers define validity.
  always_ff @(posedge clk_i) begin
    if (enq && !reset_i) mem[wptr_r[addr_w-1:0]] <= data_i;
  end

  // Protocol checks on consumer-side inputs (not evaluated in clear cycles).
  always @(posedge clk_i) begin
    if (!reset_i && !clr_v_i) begin
      assert (!yumi_i || v_o)
        else $error("yumi_i raised while v_o is low");
      assert ((ptr_w+1)'(commit_cnt_i) <= (ptr_w+1)'(inflight_o) + (ptr_w+1)'(yumi_i))
        else $error("commit_cnt_i exceeds in-flight entries");
    end
  end

`ifdef BP_FE_REPLAY_QUEUE_STATS_EN
  logic [31:0]      roll_cnt_r, replay_cnt_r;
  logic [ptr_w-1:0] rewound;
  logic             roll_eff;
  logic [32:0]      replay_sum;

  // A roll counts only when something was actually read (before or in this cycle).
  assign roll_eff   = roll_v_i & ~clr_v_i & ((inflight_o != '0) | yumi_i);
  assign rewound    = rptr_r + ptr_w'(yumi_i) - cptr_n;
  assign replay_sum = {1'b0, replay_cnt_r} + 33'(rewound);

  // Saturating statistics counters; only reset clears them, clr_v_i does not.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      roll_cnt_r   <= '0;
      replay_cnt_r <= '0;
    end else if (roll_eff) begin
      if (roll_cnt_r != 32'hFFFF_FFFF) roll_cnt_r <= roll_cnt_r + 32'd1;
      replay_cnt_r <= replay_sum[32] ? 32'hFFFF_FFFF : replay_sum[31:0];
    end
  end

  assign roll_cnt_o   = roll_cnt_r;
  assign replay_cnt_o = replay_cnt_r;
`endif

endmodule

// File: tb/tb_bp_fe_replay_queue.sv
// Testbench for bp_fe_replay_queue: directed vector table for the documented
// corner cases, then randomized traffic checked against a queue-based model.
module tb_bp_fe_replay_queue;
  localparam int W  = 64;
  localparam int E  = 8;
  localparam int CW = 2;

  // Clock / reset
  logic          clk = 1'b0;
  logic          reset_i, clr_v_i, roll_v_i, v_i, yumi_i;
  logic [1:0]    commit_cnt_i;
  logic [W-1:0]  data_i, data_o;
  logic          ready_o, v_o;
  logic [3:0]    count_o, inflight_o;
`ifdef BP_FE_REPLAY_QUEUE_STATS_EN
  logic [31:0]   roll_cnt_o, replay_cnt_o;
`endif

  always #5 clk = ~clk;

  bp_fe_replay_queue #(.width_p(W), .els_p(E), .commit_width_p(CW)) dut (
    .clk_i(clk), .reset_i(reset_i), .clr_v_i(clr_v_i), .roll_v_i(roll_v_i),
    .commit_cnt_i(commit_cnt_i), .data_i(data_i), .v_i(v_i), .ready_o(ready_o),
    .data_o(data_o), .v_o(v_o), .yumi_i(yumi_i), .count_o(count_o),
    .inflight_o(inflight_o)
`ifdef BP_FE_REPLAY_QUEUE_STATS_EN
    , .roll_cnt_o(roll_cnt_o), .replay_cnt_o(replay_cnt_o)
`endif
  );

  // Vector table
  typedef struct {
    logic         rst, clr, roll, v, yumi;
    int           commit;
    logic [W-1:0] data;
    logic         er, ev;
    int           ec, ei;
    logic [W-1:0] ed;
    int           erc, erp;   // expected stats, -1 = not checked
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  function automatic void add(input logic rst, clr, roll, v, yumi, input int commit,
                              input logic [W-1:0] data, input logic er, ev,
                              input int ec, ei, input logic [W-1:0] ed,
                              input int erc = -1, input int erp = -1);
    vec_t t;
    t.rst = rst; t.clr = clr; t.roll = roll; t.v = v; t.yumi = yumi;
    t.commit = commit; t.data = data; t.er = er; t.ev = ev;
    t.ec = ec; t.ei = ei; t.ed = ed; t.erc = erc; t.erp = erp;
    vecs.push_back(t);
  endfunction

  function automatic logic [W-1:0] tag(input logic [15:0] pfx, input int i);
    return {pfx, 48'(i)};
  endfunction

  // Scoreboard compare
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver
  task automatic drive(input logic rst, clr, roll, v, yumi, input int commit,
                       input logic [W-1:0] data);
    reset_i = rst; clr_v_i = clr; roll_v_i = roll; v_i = v; yumi_i = yumi;
    commit_cnt_i = 2'(commit); data_i = data;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string pfx, input logic er, ev, input int ec, ei,
                             input logic [W-1:0] ed);
    check({pfx, " ready_o"}, W'(ready_o), W'(er));
    check({pfx, " v_o"}, W'(v_o), W'(ev));
    check({pfx, " count_o"}, W'(count_o), W'(ec));
    check({pfx, " inflight_o"}, W'(inflight_o), W'(ei));
    if (ev) check({pfx, " data_o"}, data_o, ed);
  endtask

  // Behavioural model: list of resident entries (oldest uncommitted first)
  // plus how many of them have been read.
  logic [W-1:0] mq[$];
  int           m_read;
  int           m_rolls, m_replays;

  function automatic void model_reset();
    mq.delete(); m_read = 0; m_rolls = 0; m_replays = 0;
  endfunction

  function automatic void model_cycle(input logic clr, roll, v, yumi, input int commit,
                                      input logic [W-1:0] data);
    logic had_room;
    if (clr) begin
      mq.delete();
      m_read = 0;
      return;
    end
    had_room = (mq.size() < E);
    if (roll && (m_read + int'(yumi)) > 0) begin
      m_rolls++;
      m_replays += m_read + int'(yumi) - commit;
    end
    m_read += int'(yumi);
    for (int k = 0; k < commit; k++) begin
      void'(mq.pop_front());
      m_read--;
    end
    if (roll) m_read = 0;
    if (v && had_room) mq.push_back(data);
  endfunction

  initial begin
    logic [W-1:0] A0, A1, A2, E0, E1, E2;
    drive(1, 0, 0, 0, 0, 0, '0);
    step(); step();

    // Fill, then over-fill, read three, commit one with roll.
    A0 = tag(16'hA000, 0); A1 = tag(16'hA000, 1); A2 = tag(16'hA000, 2);
    add(1,0,0,0,0,0,'0, 1,0,0,0,'0, 0,0);
    for (int i = 0; i < 8; i++) add(0,0,0,1,0,0,tag(16'hA000,i), i<7,1,i+1,0,A0);
    add(0,0,0,1,0,0,64'hDEAD, 0,1,8,0,A0);
    for (int i = 0; i < 3; i++) add(0,0,0,0,1,0,'0, 0,1,8,i+1,tag(16'hA000,i+1));
    add(0,0,1,0,0,1,'0, 1,1,7,0,A1, 1,2);

    // Full, read two, commit two (enqueue refused in that cycle), wrap enqueue.
    add(1,0,0,0,0,0,'0, 1,0,0,0,'0, 0,0);
    for (int i = 0; i < 8; i++) add(0,0,0,1,0,0,tag(16'hA000,i), i<7,1,i+1,0,A0);
    for (int i = 0; i < 2; i++) add(0,0,0,0,1,0,'0, 0,1,8,i+1,tag(16'hA000,i+1));
    add(0,0,0,1,0,2,64'hBAD0, 1,1,6,0,A2);
    add(0,0,0,1,0,0,tag(16'hB000,0), 1,1,7,0,A2);
    for (int k = 0; k < 7; k++)
      add(0,0,0,0,1,0,'0, 1,k<6,7,k+1, (k<5) ? tag(16'hA000,k+3) : tag(16'hB000,0));
    add(0,0,0,0,0,2,'0, 1,0,5,5,'0);

    // Clear beats enqueue, yumi, commit and roll in the same cycle.
    add(1,0,0,0,0,0,'0, 1,0,0,0,'0);
    for (int i = 0; i < 4; i++) add(0,0,0,1,0,0,tag(16'hD000,i), 1,1,i+1,0,tag(16'hD000,0));
    add(0,1,1,1,1,1,tag(16'hC000,0), 1,0,0,0,'0);
    add(0,0,0,1,0,0,tag(16'hD000,9), 1,1,1,0,tag(16'hD000,9));

    // Yumi inside a roll cycle, roll with nothing in flight, stats across clear.
    E0 = tag(16'hE000,0); E1 = tag(16'hE000,1); E2 = tag(16'hE000,2);
    add(1,0,0,0,0,0,'0, 1,0,0,0,'0, 0,0);
    for (int i = 0; i < 3; i++) add(0,0,0,1,0,0,tag(16'hE000,i), 1,1,i+1,0,E0);
    add(0,0,0,0,1,0,'0, 1,1,3,1,E1);
    add(0,0,0,0,1,0,'0, 1,1,3,2,E2);
    add(0,0,1,0,1,0,'0, 1,1,3,0,E0, 1,3);
    add(0,0,1,0,0,0,'0, 1,1,3,0,E0, 1,3);
    add(0,0,0,0,1,0,'0, 1,1,3,1,E1);
    add(0,1,0,0,0,0,'0, 1,0,0,0,'0, 1,3);

    // Reset mid-stream.
    for (int i = 0; i < 5; i++) add(0,0,0,1,0,0,tag(16'hF000,i), 1,1,i+1,0,tag(16'hF000,0));
    add(0,0,0,0,1,0,'0, 1,1,5,1,tag(16'hF000,1));
    add(0,0,0,0,1,0,'0, 1,1,5,2,tag(16'hF000,2));
    add(1,0,0,0,0,0,'0, 1,0,0,0,'0, 0,0);

    for (int n = 0; n < vecs.size(); n++) begin
      string nm;
      nm = $sformatf("vec%0d", n);
      drive(vecs[n].rst, vecs[n].clr, vecs[n].roll, vecs[n].v, vecs[n].yumi,
            vecs[n].commit, vecs[n].data);
      step();
      check_state(nm, vecs[n].er, vecs[n].ev, vecs[n].ec, vecs[n].ei, vecs[n].ed);
`ifdef BP_FE_REPLAY_QUEUE_STATS_EN
      if (vecs[n].erc >= 0) check({nm, " roll_cnt_o"}, W'(roll_cnt_o), W'(vecs[n].erc));
      if (vecs[n].erp >= 0) check({nm, " replay_cnt_o"}, W'(replay_cnt_o), W'(vecs[n].erp));
`endif
    end

    // Randomized traffic against the model.
    drive(1, 0, 0, 0, 0, 0, '0);
    step();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic r_clr, r_roll, r_v, r_yumi;
      int   r_commit, lim;
      logic [W-1:0] r_data;
      r_clr  = ($urandom_range(0, 39) == 0);
      r_roll = ($urandom_range(0, 9) == 0);
      r_v    = ($urandom_range(0, 9) < 6);
      r_yumi = (m_read < mq.size()) && ($urandom_range(0, 9) < 6);
      lim    = m_read + int'(r_yumi);
      if (lim > CW) lim = CW;
      r_commit = (lim > 0) ? int'($urandom_range(0, lim)) : 0;
      r_data = {$urandom, $urandom};
      drive(0, r_clr, r_roll, r_v, r_yumi, r_commit, r_data);
      model_cycle(r_clr, r_roll, r_v, r_yumi, r_commit, r_data);
      step();
      check_state($sformatf("rnd%0d", c), mq.size() < E, m_read < mq.size(),
                  mq.size(), m_read, (m_read < mq.size()) ? mq[m_read] : '0);
`ifdef BP_FE_REPLAY_QUEUE_STATS_EN
      check($sformatf("rnd%0d roll_cnt_o", c), W'(roll_cnt_o), W'(m_rolls));
      check($sformatf("rnd%0d replay_cnt_o", c), W'(replay_cnt_o), W'(m_replays));
`endif
    end

    drive(0, 0, 0, 0, 0, 0, '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bp_fe_replay_queue.md
Name: bp_fe_replay_queue

Overview:
- Parametrised rollback queue: the next generation of the single-commit rolly FIFO that sits between the fetch-address source and the I$.
- Entries are held after being read until they are explicitly committed. A roll rewinds the read pointer to the oldest uncommitted entry so fetches that missed are replayed.
- Adds over the previous generation: multi-entry commit per cycle, occupancy/in-flight status outputs, and optional replay statistics.

Parameters:
- width_p, 64, payload bits per entry ({uncached, vaddr, ptag} in FE use)
- els_p, 8, entry count; power of 2, >= 2
- commit_width_p, 2, max entries committed per cycle; 1 <= commit_width_p <= els_p

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- clr_v_i  in  1  flush all entries
- roll_v_i  in  1  rewind read pointer to commit pointer
- commit_cnt_i  in  clog2(commit_width_p+1)  entries to retire this cycle (0 = none)
- data_i  in  width_p  enqueue payload
- v_i  in  1  enqueue valid
- ready_o  out  1  space available
- data_o  out  width_p  entry at read pointer
- v_o  out  1  data_o valid (unread entry exists)
- yumi_i  in  1  consumer takes data_o
- count_o  out  clog2(els_p+1)  wptr-cptr (total occupancy)
- inflight_o  out  clog2(els_p+1)  rptr-cptr (read, not committed)

Behaviour:
- One clock. Reset is synchronous and active-high (reset_i sampled on rising clk_i).
- State: wptr, rptr, cptr, each clog2(els_p)+1 bits, with the extra bit as the wrap bit. Storage is async-read 1r1w, els_p x width_p.
- Reset: all pointers 0. Outputs after reset: ready_o=1, v_o=0, count_o=0, inflight_o=0, data_o don't-care.
- ready_o = (count_o != els_p). v_o = (rptr != wptr). Both depend only on registered state, never on same-cycle inputs.
- Enqueue: v_i & ready_o writes mem[wptr] and increments wptr. v_i while ready_o=0 is ignored. No bypass: an entry enqueued in cycle N is visible on data_o in N+1 at the earliest.
- Read: yumi_i is legal only when v_o=1 (assert otherwise). It increments rptr.
- Commit: cptr_n = cptr + commit_cnt_i. commit_cnt_i must be <= inflight_o, counting a same-cycle yumi (assert otherwise). Committed slots are freed: ready_o can rise the next cycle.
- Roll: rptr_n = cptr_n, i.e. the rewind lands after this cycle's commit. A yumi_i in the roll cycle is discarded. A same-cycle enqueue is kept. The next cycle replays from the oldest uncommitted entry.
- Clear: wptr_n = rptr_n = cptr_n = wptr. The queue becomes empty, ready_o=1, and a same-cycle enqueue is dropped. Commit, roll and yumi in that cycle are ignored.
- Priority: reset > clr > roll > (enqueue, yumi, commit, all concurrent).
- Wrap-around: pointer arithmetic is mod 2*els_p. Full when the low bits are equal and the wrap bits differ; empty/no-unread when all bits are equal.
- Full with a same-cycle commit: enqueue is still refused that cycle, because ready_o is registered-state only.
- Roll with inflight_o=0: no effect.
- Reset mid-operation discards all contents. No partial state survives.

Optional Feature:
- Macro: BP_FE_REPLAY_QUEUE_STATS_EN.
- When defined, adds ports:
  - roll_cnt_o  out  32: increments on each roll_v_i with inflight_o+yumi_i > 0.
  - replay_cnt_o  out  32: adds the entries rewound on each such roll (rptr+yumi_i-cptr_n).
- Both counters saturate at 2^32-1, reset to 0, and are unaffected by clr_v_i.
- When not defined: the ports are absent and no counter logic is generated. Core behaviour is identical in both builds.

Test Plan:
- Fill, els_p=8: enqueue A0..A7 with no reads -> ready_o=0 after 8th enqueue, count_o=8; 9th v_i ignored; data_o=A0, v_o=1.
- Read and roll: read A0..A2 (inflight_o=3), commit_cnt_i=1 together with roll_v_i -> next cycle data_o=A1, inflight_o=0, count_o=7.
- Multi-commit free-up: full queue, read 2, commit_cnt_i=2 -> ready_o=1 next cycle, count_o=6; enqueue B0 lands in slot 0 (wrap), read order preserved: A2..A7,B0.
- Clear vs. enqueue: 4 entries, clr_v_i with v_i=1 (C0) and yumi_i=1 -> next cycle v_o=0, count_o=0, ready_o=1; C0 never appears.
- Yumi in roll cycle: inflight_o=2, yumi_i=1, roll_v_i=1, commit_cnt_i=0 -> rptr=cptr; same entry re-presented next cycle. With STATS_EN: roll_cnt_o=1, replay_cnt_o=3.
- Reset mid-stream: 5 entries, inflight 2, assert reset_i one cycle -> count_o=0, inflight_o=0, v_o=0, ready_o=1, stats counters 0.
